i2c_flash_target: RTL and testbench

I2C target (slave) engine that sits on the SCL/SDA pins on the opposite end of the bus from the team's byte shift-register initiator. It decodes START/STOP, matches a 7-bit device address and ACKs it. On writes it loads a word pointer, then writes data bytes into a byte-wide memory port. On reads it shifts memory bytes out MSB first. A system clock oversamples the bus; SDA is open-drain via an output-enable.

---
 rtl/i2c_flash_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_flash_target.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_flash_target.sv
`timescale 1ns/1ps
// I2C target: START/STOP decode, 7-bit address match, word pointer load,
// byte writes to a memory port and MSB-first reads, oversampled by Clk.
module i2c_flash_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Scl,
    input  logic              SdaIn,
    output logic              SdaOe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWData,
    output logic              MemWe,
    input  logic [7:0]        MemRData,
    output logic              Busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t state_q, state_d;
    // [0],[1] synchronizer, [2] history for edge detection
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic rw_q, rw_d;
    logic oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic we_q, we_d;
    logic busy_q, busy_d;
    logic [7:0] byte_in;
    logic rd_load;
    logic scl_rise, scl_fall, scl_hi, bus_start, bus_stop;

    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign scl_hi    = scl_sync_q[1] & scl_sync_q[2];
    assign bus_start = scl_hi & ~sda_sync_q[1] & sda_sync_q[2];
    assign bus_stop  = scl_hi & sda_sync_q[1] & ~sda_sync_q[2];

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], Scl};
        sda_sync_d = {sda_sync_q[1:0], SdaIn};
        byte_in = {shift_q[6:0], sda_sync_q[1]};
        state_d = state_q;
        cnt_d = cnt_q;
        shift_d = shift_q;
        rw_d = rw_q;
        oe_d = oe_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        we_d = 1'b0;
        rd_load = 1'b0;
        // pointer advances on the Clk after each write strobe
        if (we_q) addr_d = addr_q + ADDR_W'(1);
        unique case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
                if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (state_q == S_ADDR) begin
                            rw_d = byte_in[0];
                            state_d = (byte_in[7:1] == DEV_ADDR) ?
                                      S_ADDR_ACK : S_IGNORE;
                        end else if (state_q == S_PTR) begin
                            addr_d = ADDR_W'(byte_in);
                            state_d = S_PTR_ACK;
                        end else begin
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                if (scl_fall && !oe_q) begin
                    oe_d = 1'b1;
                    if (state_q == S_WDATA_ACK) begin
                        wdata_d = shift_q;
                        we_d = 1'b1;
                    end
                end else if (scl_fall) begin
                    oe_d = 1'b0;
                    cnt_d = '0;
                    if (state_q != S_ADDR_ACK) begin
                        state_d = S_WDATA;
                    end else if (rw_q) begin
                        state_d = S_RDATA;
                        rd_load = 1'b1;
                    end else begin
                        state_d = S_PTR;
                    end
                end
            end
            S_RDATA: begin
                if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        rd_load = 1'b1;
                    end else if (cnt_q == 4'd8) begin
                        oe_d = 1'b0;
                        cnt_d = '0;
                        state_d = S_RDATA_ACK;
                    end else begin
                        oe_d = ~shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_RDATA_ACK: begin
                if (scl_rise) state_d = sda_sync_q[1] ? S_IGNORE : S_RDATA;
            end
            default: ;
        endcase
        if (rd_load) begin
            oe_d = ~MemRData[7];
            shift_d = {MemRData[6:0], 1'b0};
            addr_d = addr_q + ADDR_W'(1);
            cnt_d = 4'd1;
        end
        if (bus_start) begin
            state_d = S_ADDR;
            cnt_d = '0;
            oe_d = 1'b0;
        end else if (bus_stop) begin
            state_d = S_IDLE;
            cnt_d = '0;
            oe_d = 1'b0;
        end
        busy_d = !(state_d inside {S_IDLE, S_ADDR, S_IGNORE});
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            cnt_q <= '0;
            shift_q <= '0;
            rw_q <= 1'b0;
            oe_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            rw_q <= rw_d;
            oe_q <= oe_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            we_q <= we_d;
            busy_q <= busy_d;
        end
    end

    assign SdaOe = oe_q;
    assign MemAddr = addr_q;
    assign MemWData = wdata_q;
    assign MemWe = we_q;
    assign Busy = busy_q;
endmodule

// File: tb/tb_i2c_flash_target.sv
`timescale 1ns/1ps
// Bench for i2c_flash_target: directed vector table, hand-written corner
// sequences and random transactions against a transaction-level model.
module tb_i2c_flash_target;
    localparam logic [6:0] DEV = 7'h50;

    logic Clk = 1'b0;
    logic Rst_n;
    logic Scl;
    logic m_sda;
    logic SdaIn;
    logic SdaOe;
    logic [7:0] MemAddr;
    logic [7:0] MemWData;
    logic MemWe;
    logic [7:0] MemRData;
    logic Busy;

    always #5 Clk = ~Clk;
    assign SdaIn = m_sda & ~SdaOe;

    i2c_flash_target #(.DEV_ADDR(DEV), .ADDR_W(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Scl(Scl), .SdaIn(SdaIn),
        .SdaOe(SdaOe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWe(MemWe), .MemRData(MemRData), .Busy(Busy)
    );

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a * 8'd7 + 8'd3;
    endfunction

    // memory attached to the port; logs every write strobe
    logic [7:0] mem [256];
    logic mem_ok = 1'b0;
    logic [15:0] wlog [$];
    int oe_cnt = 0;
    int busy_cnt = 0;
    assign MemRData = mem[MemAddr];

    always @(posedge Clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
            mem_ok <= 1'b1;
        end else if (MemWe) begin
            mem[MemAddr] <= MemWData;
            wlog.push_back({MemAddr, MemWData});
        end
        if (SdaOe) oe_cnt <= oe_cnt + 1;
        if (Busy) busy_cnt <= busy_cnt + 1;
    end

    // transaction-level model
    logic [7:0] exp_mem [256];
    logic [7:0] exp_ptr;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic ack_q [$];
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] dev;
        logic rd;
        logic has_ptr;
        logic [7:0] ptr;
        int n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic exp_ack;
        int exp_we;
        logic [7:0] exp_addr;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        wait_clk(3);
        m_sda = b;
        wait_clk(3);
        Scl = 1'b1;
        wait_clk(3);
        r = SdaIn;
        wait_clk(3);
        Scl = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        wait_clk(3);
        Scl = 1'b1;
        wait_clk(6);
        m_sda = 1'b0;
        wait_clk(6);
        Scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(3);
        m_sda = 1'b0;
        wait_clk(3);
        Scl = 1'b1;
        wait_clk(6);
        m_sda = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic r;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, r);
            b = {b[6:0], r};
        end
        clock_bit(nack, r);
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] ptr);
        logic a;
        ack_q.delete();
        bus_start();
        send_byte(dev, a);
        ack_q.push_back(a);
        send_byte(ptr, a);
        ack_q.push_back(a);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], a);
            ack_q.push_back(a);
        end
        bus_stop();
    endtask

    task automatic do_read(input logic [7:0] dev, input logic has_ptr,
                           input logic [7:0] ptr, input int n);
        logic a;
        logic [7:0] b;
        ack_q.delete();
        rx_q.delete();
        bus_start();
        if (has_ptr) begin
            send_byte({dev[7:1], 1'b0}, a);
            ack_q.push_back(a);
            send_byte(ptr, a);
            ack_q.push_back(a);
            bus_start();
        end
        send_byte(dev, a);
        ack_q.push_back(a);
        if (a == 1'b0) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, b);
                rx_q.push_back(b);
            end
        end
        bus_stop();
    endtask

    function automatic void model_write(input logic [7:0] dev,
                                        input logic [7:0] ptr);
        if (dev != {DEV, 1'b0}) return;
        exp_ptr = ptr;
        foreach (tx_q[i]) begin
            exp_mem[exp_ptr] = tx_q[i];
            exp_ptr = exp_ptr + 8'd1;
        end
    endfunction

    task automatic check_idle();
        check("mem_addr", 32'(MemAddr), 32'(exp_ptr));
        check("sda_released", 32'(SdaOe), 0);
        check("busy_idle", 32'(Busy), 0);
    endtask

    task automatic check_write_txn(input logic [7:0] dev, input logic [7:0] ptr,
                                   input int wb, input int ob, input int bb);
        logic matched;
        logic [31:0] act;
        matched = (dev == {DEV, 1'b0});
        foreach (ack_q[i]) check("wr_ack", 32'(ack_q[i]), 32'(!matched));
        check("we_count", wlog.size() - wb, matched ? tx_q.size() : 0);
        if (matched) begin
            foreach (tx_q[i]) begin
                act = (wb + i < wlog.size()) ? 32'(wlog[wb + i]) : '1;
                check("wr_entry", act, 32'({ptr + 8'(i), tx_q[i]}));
            end
        end else begin
            check("oe_quiet", oe_cnt - ob, 0);
            check("busy_quiet", busy_cnt - bb, 0);
        end
        model_write(dev, ptr);
        check_idle();
    endtask

    task automatic check_read_txn(input logic has_ptr, input logic [7:0] ptr,
                                  input int n);
        logic [31:0] act;
        foreach (ack_q[i]) check("rd_ack", 32'(ack_q[i]), 0);
        check("rx_count", rx_q.size(), n);
        if (has_ptr) exp_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            act = (i < rx_q.size()) ? 32'(rx_q[i]) : '1;
            check("rd_byte", act, 32'(exp_mem[exp_ptr]));
            exp_ptr = exp_ptr + 8'd1;
        end
        check_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic r;
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] exp_b;
        logic [31:0] act;
        int wb, ob, bb, idx, kind, n;

        vt[0] = '{8'hA0, 1'b0, 1'b1, 8'h10, 2, 8'h5A, 8'hC3, 1'b0, 2, 8'h12};
        vt[1] = '{8'hA2, 1'b0, 1'b1, 8'h33, 2, 8'h77, 8'h88, 1'b1, 0, 8'h12};
        vt[2] = '{8'hA1, 1'b1, 1'b1, 8'h10, 2, 8'h5A, 8'hC3, 1'b0, 0, 8'h12};
        vt[3] = '{8'hA0, 1'b0, 1'b1, 8'hFF, 2, 8'h11, 8'h22, 1'b0, 2, 8'h01};
        vt[4] = '{8'hA1, 1'b1, 1'b0, 8'h00, 2, 8'h0A, 8'h11, 1'b0, 0, 8'h03};
        vt[5] = '{8'hA3, 1'b1, 1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 0, 8'h03};
        for (int i = 0; i < 256; i++) exp_mem[i] = pat(8'(i));
        exp_ptr = '0;

        Rst_n = 1'b0;
        Scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(4);
        check("rst_oe", 32'(SdaOe), 0);
        check("rst_addr", 32'(MemAddr), 0);
        check("rst_wdata", 32'(MemWData), 0);
        check("rst_we", 32'(MemWe), 0);
        check("rst_busy", 32'(Busy), 0);
        Rst_n = 1'b1;
        wait_clk(4);

        for (int v = 0; v < 6; v++) begin
            tx_q.delete();
            if (vt[v].n > 0) tx_q.push_back(vt[v].d0);
            if (vt[v].n > 1) tx_q.push_back(vt[v].d1);
            wb = wlog.size();
            ob = oe_cnt;
            bb = busy_cnt;
            if (!vt[v].rd) begin
                do_write(vt[v].dev, vt[v].ptr);
                model_write(vt[v].dev, vt[v].ptr);
                idx = 0;
            end else begin
                do_read(vt[v].dev, vt[v].has_ptr, vt[v].ptr, vt[v].n);
                if (vt[v].has_ptr) exp_ptr = vt[v].ptr;
                exp_ptr = exp_ptr + 8'(vt[v].n);
                idx = vt[v].has_ptr ? 2 : 0;
            end
            check($sformatf("v%0d_dev_ack", v), 32'(ack_q[idx]),
                  32'(vt[v].exp_ack));
            check($sformatf("v%0d_we_count", v), wlog.size() - wb,
                  vt[v].exp_we);
            for (int i = 0; i < vt[v].exp_we; i++) begin
                act = (wb + i < wlog.size()) ? 32'(wlog[wb + i]) : '1;
                exp_b = (i == 0) ? vt[v].d0 : vt[v].d1;
                check($sformatf("v%0d_wr%0d", v, i), act,
                      32'({vt[v].ptr + 8'(i), exp_b}));
            end
            if (vt[v].rd) begin
                for (int i = 0; i < vt[v].n; i++) begin
                    act = (i < rx_q.size()) ? 32'(rx_q[i]) : '1;
                    exp_b = (i == 0) ? vt[v].d0 : vt[v].d1;
                    check($sformatf("v%0d_rd%0d", v, i), act, 32'(exp_b));
                end
            end
            if (vt[v].exp_ack) begin
                check($sformatf("v%0d_oe_quiet", v), oe_cnt - ob, 0);
                check($sformatf("v%0d_busy_quiet", v), busy_cnt - bb, 0);
            end else begin
                check($sformatf("v%0d_busy_seen", v), 32'(busy_cnt != bb), 1);
            end
            check($sformatf("v%0d_addr", v), 32'(MemAddr),
                  32'(vt[v].exp_addr));
            check($sformatf("v%0d_oe_end", v), 32'(SdaOe), 0);
            check($sformatf("v%0d_busy_end", v), 32'(Busy), 0);
        end

        // STOP four bits into a data byte
        wb = wlog.size();
        bus_start();
        send_byte(8'hA0, a);
        check("abort_dev_ack", 32'(a), 0);
        send_byte(8'h20, a);
        check("abort_ptr_ack", 32'(a), 0);
        clock_bit(1'b1, r);
        clock_bit(1'b0, r);
        clock_bit(1'b1, r);
        clock_bit(1'b1, r);
        bus_stop();
        exp_ptr = 8'h20;
        check("abort_no_we", wlog.size() - wb, 0);
        check_idle();
        // a byte without START must be ignored from IDLE
        Scl = 1'b0;
        send_byte(8'hA0, a);
        check("idle_no_ack", 32'(a), 1);
        bus_stop();
        check("idle_no_we", wlog.size() - wb, 0);

        // reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            exp_b = 8'hA0;
            clock_bit(exp_b[i], r);
        end
        for (int k = 0; k < 20 && !SdaOe; k++) wait_clk(1);
        check("pre_rst_oe", 32'(SdaOe), 1);
        check("pre_rst_busy", 32'(Busy), 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_rst_oe", 32'(SdaOe), 0);
        check("async_rst_addr", 32'(MemAddr), 0);
        check("async_rst_wdata", 32'(MemWData), 0);
        check("async_rst_busy", 32'(Busy), 0);
        Scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(4);
        Rst_n = 1'b1;
        wait_clk(4);
        exp_ptr = '0;
        tx_q.delete();
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        wb = wlog.size();
        ob = oe_cnt;
        bb = busy_cnt;
        do_write(8'hA0, 8'h40);
        check_write_txn(8'hA0, 8'h40, wb, ob, bb);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            ptr = 8'($urandom);
            n = $urandom_range(1, 3);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            wb = wlog.size();
            ob = oe_cnt;
            bb = busy_cnt;
            if (kind == 0) begin
                dev = {DEV, 1'b0};
                if ($urandom_range(0, 3) == 0)
                    dev = {DEV ^ 7'($urandom_range(1, 127)), 1'b0};
                do_write(dev, ptr);
                check_write_txn(dev, ptr, wb, ob, bb);
            end else begin
                do_read({DEV, 1'b1}, kind == 1, ptr, n);
                check_read_txn(kind == 1, ptr, n);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
